// File: rtl/mptw_pipeline_ctrl_if.sv
// Handshake bundle between the CPU-side request port, the walker pipeline and the system side.
// The controller uses the slave modport; the environment driving it uses master.
interface mptw_pipeline_ctrl_if;
  logic valid_req_i;
  logic pipeline_valid_i;
  logic pipeline_ready_i;
  logic system_valid_o;
  logic system_ready_o;

  modport master (
    output valid_req_i,
    output pipeline_valid_i,
    output pipeline_ready_i,
    input  system_valid_o,
    input  system_ready_o
  );

  modport slave (
    input  valid_req_i,
    input  pipeline_valid_i,
    input  pipeline_ready_i,
    output system_valid_o,
    output system_ready_o
  );
endinterface

// File: rtl/mptw_pipeline_ctrl.sv
// Flush/stall controller for the MPT walker pipeline with STAGES_NUM stages.
// Optional flush watchdog enabled by defining MPTW_CTRL_FLUSH_TIMEOUT_EN.
module mptw_pipeline_ctrl #(
  parameter int unsigned STAGES_NUM           = 4,
  parameter int unsigned FLUSH_TIMEOUT_CYCLES = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  mptw_pipeline_ctrl_if.slave       hs,
  input  logic                      flush_all_i,
  input  logic                      flush_spec_i,
  input  logic                      error_i,
  input  logic                      stall_i,
  input  logic [STAGES_NUM-1:0]     stage_busy_i,
  input  logic [STAGES_NUM-1:0]     stage_spec_i,
  input  logic [STAGES_NUM-1:0]     flush_ack_i,
  output logic [2*STAGES_NUM-1:0]   flush_ctrl_o,
  output logic                      busy_o,
  output logic                      stalled_o,
  output logic                      flush_done_o,
  output logic                      flush_timeout_o
);

  typedef enum logic [2:0] {StIdle, StRunning, StFlush, StStall, StStallFlush} state_e;
  typedef enum logic [1:0] {FcNone = 2'd0, FcSpec = 2'd1, FcAll = 2'd2} ftype_e;

  state_e                  state_q, state_d;
  ftype_e                  ftype_q, ftype_d;
  logic [STAGES_NUM-1:0]   pending_q, pending_d;
  logic [2*STAGES_NUM-1:0] flush_ctrl_q, flush_ctrl_d;
  logic                    done_q, done_d;
  logic                    stall_cond, req_all, req_spec, upgrade;
  state_e                  run_next, post_next;

`ifdef MPTW_CTRL_FLUSH_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(FLUSH_TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
`endif

  always_comb begin
    stall_cond = stall_i | ~hs.pipeline_ready_i;
    req_all    = flush_all_i | error_i;
    req_spec   = flush_spec_i & ~req_all;
    upgrade    = 1'b0;

    run_next  = stall_cond ? StStall :
                (((hs.valid_req_i & hs.pipeline_ready_i) | (|stage_busy_i)) ? StRunning : StIdle);
    post_next = stall_cond ? StStall : (hs.valid_req_i ? StRunning : StIdle);

    state_d   = state_q;
    ftype_d   = ftype_q;
    pending_d = pending_q;
    done_d    = 1'b0;
`ifdef MPTW_CTRL_FLUSH_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif

    unique case (state_q)
      StIdle, StRunning, StStall: begin
        if (req_all || req_spec) begin
          state_d   = stall_cond ? StStallFlush : StFlush;
          ftype_d   = req_all ? FcAll : FcSpec;
          pending_d = req_all ? {STAGES_NUM{1'b1}} : stage_spec_i;
`ifdef MPTW_CTRL_FLUSH_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end else begin
          state_d = run_next;
        end
      end
      StFlush, StStallFlush: begin
        // Acks retire first so a same-cycle request can re-arm a stage.
        pending_d = pending_q & ~flush_ack_i;
        if (req_all) begin
          upgrade   = 1'b1;
          ftype_d   = FcAll;
          pending_d = {STAGES_NUM{1'b1}};
        end else if (req_spec && ftype_q == FcSpec) begin
          pending_d = pending_d | stage_spec_i;
        end
`ifdef MPTW_CTRL_FLUSH_TIMEOUT_EN
        if (upgrade) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_d == CntW'(FLUSH_TIMEOUT_CYCLES) && pending_d != '0) begin
            pending_d = '0;
            timeout_d = 1'b1;
          end
        end
`endif
        if (pending_d == '0) begin
          done_d  = 1'b1;
          ftype_d = FcNone;
          state_d = post_next;
        end else begin
          state_d = stall_cond ? StStallFlush : StFlush;
        end
      end
      default: state_d = StIdle;
    endcase

    flush_ctrl_d = '0;
    for (int unsigned i = 0; i < STAGES_NUM; i++) begin
      flush_ctrl_d[2*i +: 2] = pending_d[i] ? ftype_d : FcNone;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      ftype_q      <= FcNone;
      pending_q    <= '0;
      flush_ctrl_q <= '0;
      done_q       <= 1'b0;
`ifdef MPTW_CTRL_FLUSH_TIMEOUT_EN
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ftype_q      <= ftype_d;
      pending_q    <= pending_d;
      flush_ctrl_q <= flush_ctrl_d;
      done_q       <= done_d;
`ifdef MPTW_CTRL_FLUSH_TIMEOUT_EN
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  logic pass_hs;

  always_comb begin
    pass_hs   = (state_q == StIdle || state_q == StRunning) &&
                !(req_all || flush_spec_i) && !stall_cond;
    busy_o    = (state_q == StFlush || state_q == StStallFlush) ? 1'b1 :
                (state_q == StRunning || state_q == StStall) ? (|stage_busy_i) : 1'b0;
    stalled_o = (state_q == StStall || state_q == StStallFlush);
    hs.system_valid_o = pass_hs & hs.pipeline_valid_i;
    hs.system_ready_o = pass_hs & hs.pipeline_ready_i;
  end

  assign flush_ctrl_o = flush_ctrl_q;
  assign flush_done_o = done_q;
`ifdef MPTW_CTRL_FLUSH_TIMEOUT_EN
  assign flush_timeout_o = timeout_q;
`else
  assign flush_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_mptw_pipeline_ctrl.sv
// Bench for mptw_pipeline_ctrl: directed vector table, hand sequences and random stimulus
// checked against a behavioural model of the flush/stall rules.
module tb_mptw_pipeline_ctrl;
  localparam int unsigned N  = 4;
  localparam int unsigned TO = 8;

  typedef struct packed {
    logic       rst, vr, pv, pr, fa, fs, er, st;
    logic [3:0] busy, spec, ack;
  } in_t;

  typedef struct packed {
    in_t        i;
    logic [7:0] ctrl;
    logic       done, sv, sr, bsy, stld;
  } vec_t;

  logic clk_i = 1'b0;
  logic rst_i, flush_all_i, flush_spec_i, error_i, stall_i;
  logic [N-1:0] stage_busy_i, stage_spec_i, flush_ack_i;
  logic [2*N-1:0] flush_ctrl_o;
  logic busy_o, stalled_o, flush_done_o, flush_timeout_o;

  mptw_pipeline_ctrl_if hs_if ();

  mptw_pipeline_ctrl #(.STAGES_NUM(N), .FLUSH_TIMEOUT_CYCLES(TO)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .hs              (hs_if.slave),
    .flush_all_i     (flush_all_i),
    .flush_spec_i    (flush_spec_i),
    .error_i         (error_i),
    .stall_i         (stall_i),
    .stage_busy_i    (stage_busy_i),
    .stage_spec_i    (stage_spec_i),
    .flush_ack_i     (flush_ack_i),
    .flush_ctrl_o    (flush_ctrl_o),
    .busy_o          (busy_o),
    .stalled_o       (stalled_o),
    .flush_done_o    (flush_done_o),
    .flush_timeout_o (flush_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  // Model: "flushing" flag, "stalled" flag, "running" flag, pending set, flush kind (0/1/2).
  bit m_fl, m_st, m_run, m_done, m_to;
  logic [3:0] m_pend;
  int m_type, m_cnt;

  logic s_sv, s_sr, s_busy, s_stld, r_done, r_to;
  logic [7:0] r_ctrl;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic in_t idle_in();
    in_t x;
    x = '0;
    x.pv = 1'b1;
    x.pr = 1'b1;
    return x;
  endfunction

  function automatic logic [7:0] exp_ctrl();
    logic [7:0] r;
    logic [1:0] t;
    t = m_type[1:0];
    r = '0;
    for (int i = 0; i < 4; i++) if (m_pend[i]) r[2*i +: 2] = t;
    return r;
  endfunction

  task automatic model_step(input in_t x);
    bit sc;
    sc = x.st | ~x.pr;
    m_done = 0;
    m_to = 0;
    if (x.rst) begin
      m_fl = 0; m_st = 0; m_run = 0; m_pend = 0; m_type = 0; m_cnt = 0;
    end else if (!m_fl) begin
      if (x.fa | x.er) begin
        m_fl = 1; m_st = sc; m_run = 0; m_pend = 4'hF; m_type = 2; m_cnt = 0;
      end else if (x.fs) begin
        m_fl = 1; m_st = sc; m_run = 0; m_pend = x.spec; m_type = 1; m_cnt = 0;
      end else begin
        m_st = sc;
        m_run = !sc && ((x.vr && x.pr) || x.busy != 0);
      end
    end else begin
      m_pend = m_pend & ~x.ack;
      if (x.fa | x.er) begin
        m_pend = 4'hF; m_type = 2; m_cnt = 0;
      end else begin
        if (x.fs && m_type == 1) m_pend = m_pend | x.spec;
`ifdef MPTW_CTRL_FLUSH_TIMEOUT_EN
        m_cnt++;
        if (m_cnt == TO && m_pend != 0) begin
          m_pend = 0;
          m_to = 1;
        end
`endif
      end
      if (m_pend == 0) begin
        m_done = 1; m_type = 0; m_fl = 0; m_st = sc; m_run = !sc && x.vr;
      end else begin
        m_st = sc;
      end
    end
  endtask

  task automatic cycle(input in_t x);
    bit pass, e_busy;
    rst_i = x.rst; flush_all_i = x.fa; flush_spec_i = x.fs; error_i = x.er; stall_i = x.st;
    stage_busy_i = x.busy; stage_spec_i = x.spec; flush_ack_i = x.ack;
    hs_if.valid_req_i = x.vr; hs_if.pipeline_valid_i = x.pv; hs_if.pipeline_ready_i = x.pr;
    #4;
    s_sv = hs_if.system_valid_o; s_sr = hs_if.system_ready_o;
    s_busy = busy_o; s_stld = stalled_o;
    pass = !m_fl && !m_st && !(x.fa | x.fs | x.er) && !(x.st | ~x.pr);
    e_busy = m_fl ? 1'b1 : ((m_run || m_st) ? (x.busy != 0) : 1'b0);
    chk("model_sys_valid", 32'(s_sv), 32'(pass & x.pv));
    chk("model_sys_ready", 32'(s_sr), 32'(pass & x.pr));
    chk("model_busy", 32'(s_busy), 32'(e_busy));
    chk("model_stalled", 32'(s_stld), 32'(m_st));
    @(posedge clk_i);
    model_step(x);
    #1;
    r_ctrl = flush_ctrl_o; r_done = flush_done_o; r_to = flush_timeout_o;
    chk("model_flush_ctrl", 32'(r_ctrl), 32'(exp_ctrl()));
    chk("model_flush_done", 32'(r_done), 32'(m_done));
    chk("model_flush_timeout", 32'(r_to), 32'(m_to));
  endtask

  function automatic vec_t row(input logic fa, fs, er, st, vr, pr, input logic [3:0] busy,
                               spec, ack, input logic [7:0] ctrl,
                               input logic done, sv, sr, bsy, stld);
    vec_t v;
    v.i = idle_in();
    v.i.fa = fa; v.i.fs = fs; v.i.er = er; v.i.st = st; v.i.vr = vr; v.i.pr = pr;
    v.i.busy = busy; v.i.spec = spec; v.i.ack = ack;
    v.ctrl = ctrl; v.done = done; v.sv = sv; v.sr = sr; v.bsy = bsy; v.stld = stld;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    in_t x;
    //              fa fs er st vr pr busy  spec   ack    ctrl   dn sv sr by sl
    // ALL flush, acks one stage per cycle
    tbl.push_back(row(1, 0, 0, 0, 0, 1, 4'h0, 4'h0, 4'h0, 8'hAA, 0, 0, 0, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 4'h0, 4'h0, 4'h1, 8'hA8, 0, 0, 0, 1, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 4'h0, 4'h0, 4'h2, 8'hA0, 0, 0, 0, 1, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 4'h0, 4'h0, 4'h4, 8'h80, 0, 0, 0, 1, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 4'h0, 4'h0, 4'h8, 8'h00, 1, 0, 0, 1, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 4'h0, 4'h0, 4'h0, 8'h00, 0, 1, 1, 0, 0));
    // Selective SPEC flush on 4'b0101, foreign acks ignored
    tbl.push_back(row(0, 1, 0, 0, 0, 1, 4'h0, 4'h5, 4'h0, 8'h11, 0, 0, 0, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 4'h0, 4'h0, 4'hA, 8'h11, 0, 0, 0, 1, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 4'h0, 4'h0, 4'h1, 8'h10, 0, 0, 0, 1, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 4'h0, 4'h0, 4'h4, 8'h00, 1, 0, 0, 1, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 4'h0, 4'h0, 4'h0, 8'h00, 0, 1, 1, 0, 0));
    // SPEC on stage 2 upgraded to ALL
    tbl.push_back(row(0, 1, 0, 0, 0, 1, 4'h0, 4'h4, 4'h0, 8'h10, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, 0, 0, 0, 0, 1, 4'h0, 4'h0, 4'h0, 8'hAA, 0, 0, 0, 1, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 4'h0, 4'h0, 4'h7, 8'h80, 0, 0, 0, 1, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 4'h0, 4'h0, 4'h8, 8'h00, 1, 0, 0, 1, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 4'h0, 4'h0, 4'h0, 8'h00, 0, 1, 1, 0, 0));
    // Stall overlapping a flush
    tbl.push_back(row(1, 0, 0, 0, 0, 1, 4'h0, 4'h0, 4'h0, 8'hAA, 0, 0, 0, 0, 0));
    tbl.push_back(row(0, 0, 0, 1, 0, 1, 4'h0, 4'h0, 4'h0, 8'hAA, 0, 0, 0, 1, 0));
    tbl.push_back(row(0, 0, 0, 1, 0, 1, 4'h0, 4'h0, 4'hF, 8'h00, 1, 0, 0, 1, 1));
    tbl.push_back(row(0, 0, 0, 1, 0, 1, 4'h0, 4'h0, 4'h0, 8'h00, 0, 0, 0, 0, 1));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 4'h0, 4'h0, 4'h0, 8'h00, 0, 0, 0, 0, 1));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 4'h0, 4'h0, 4'h0, 8'h00, 0, 1, 1, 0, 0));
    // Handshake gating by pipeline_ready_i
    tbl.push_back(row(0, 0, 0, 0, 1, 0, 4'h0, 4'h0, 4'h0, 8'h00, 0, 0, 0, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 1, 0, 4'h0, 4'h0, 4'h0, 8'h00, 0, 0, 0, 0, 1));
    tbl.push_back(row(0, 0, 0, 0, 1, 1, 4'h0, 4'h0, 4'h0, 8'h00, 0, 0, 0, 0, 1));
    tbl.push_back(row(0, 0, 0, 0, 1, 1, 4'h2, 4'h0, 4'h0, 8'h00, 0, 1, 1, 1, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 4'h0, 4'h0, 4'h0, 8'h00, 0, 1, 1, 0, 0));
    // Error acts as ALL, minimum-length flush
    tbl.push_back(row(0, 0, 1, 0, 0, 1, 4'h0, 4'h0, 4'h0, 8'hAA, 0, 0, 0, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 4'h0, 4'h0, 4'hF, 8'h00, 1, 0, 0, 1, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 4'h0, 4'h0, 4'h0, 8'h00, 0, 1, 1, 0, 0));
    // SPEC flush with empty mask finishes on its first flush cycle
    tbl.push_back(row(0, 1, 0, 0, 0, 1, 4'h0, 4'h0, 4'h0, 8'h00, 0, 0, 0, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 4'h0, 4'h0, 4'h0, 8'h00, 1, 0, 0, 1, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 4'h0, 4'h0, 4'h0, 8'h00, 0, 1, 1, 0, 0));

    // Reset
    x = idle_in();
    x.rst = 1'b1;
    cycle(x);
    cycle(x);
    chk("reset_flush_ctrl", 32'(r_ctrl), 32'h0);
    chk("reset_flush_done", 32'(r_done), 32'h0);
    chk("reset_flush_timeout", 32'(r_to), 32'h0);

    foreach (tbl[k]) begin
      cycle(tbl[k].i);
      chk($sformatf("t%0d_flush_ctrl", k), 32'(r_ctrl), 32'(tbl[k].ctrl));
      chk($sformatf("t%0d_flush_done", k), 32'(r_done), 32'(tbl[k].done));
      chk($sformatf("t%0d_sys_valid", k), 32'(s_sv), 32'(tbl[k].sv));
      chk($sformatf("t%0d_sys_ready", k), 32'(s_sr), 32'(tbl[k].sr));
      chk($sformatf("t%0d_busy", k), 32'(s_busy), 32'(tbl[k].bsy));
      chk($sformatf("t%0d_stalled", k), 32'(s_stld), 32'(tbl[k].stld));
    end

    // Reset mid-flush: no done pulse, back to idle pass-through
    x = idle_in(); x.fa = 1'b1; cycle(x);
    x = idle_in(); x.rst = 1'b1; cycle(x);
    chk("midrst_flush_ctrl", 32'(r_ctrl), 32'h0);
    chk("midrst_flush_done", 32'(r_done), 32'h0);
    x = idle_in(); x.ack = 4'hF; cycle(x);
    chk("midrst_no_done", 32'(r_done), 32'h0);
    chk("midrst_sys_valid", 32'(s_sv), 32'h1);

    // Stage 3 never acks
    x = idle_in(); x.fa = 1'b1; cycle(x);
    for (int k = 1; k <= 8; k++) begin
      x = idle_in();
      x.ack = (k == 1) ? 4'h7 : 4'h0;
      cycle(x);
`ifdef MPTW_CTRL_FLUSH_TIMEOUT_EN
      chk($sformatf("wd%0d_done", k), 32'(r_done), 32'(k == 8));
      chk($sformatf("wd%0d_timeout", k), 32'(r_to), 32'(k == 8));
      chk($sformatf("wd%0d_ctrl", k), 32'(r_ctrl), (k == 8) ? 32'h0 : 32'h80);
`else
      chk($sformatf("wd%0d_done", k), 32'(r_done), 32'h0);
      chk($sformatf("wd%0d_timeout", k), 32'(r_to), 32'h0);
      chk($sformatf("wd%0d_ctrl", k), 32'(r_ctrl), 32'h80);
`endif
    end
`ifndef MPTW_CTRL_FLUSH_TIMEOUT_EN
    for (int k = 0; k < 12; k++) begin
      cycle(idle_in());
      chk("wait_no_done", 32'(r_done), 32'h0);
    end
    x = idle_in(); x.ack = 4'h8; cycle(x);
    chk("late_ack_done", 32'(r_done), 32'h1);
`endif
    cycle(idle_in());

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      x.rst  = ($urandom_range(0, 63) == 0);
      x.vr   = $urandom_range(0, 1);
      x.pv   = $urandom_range(0, 1);
      x.pr   = ($urandom_range(0, 5) != 0);
      x.fa   = ($urandom_range(0, 15) == 0);
      x.fs   = ($urandom_range(0, 7) == 0);
      x.er   = ($urandom_range(0, 31) == 0);
      x.st   = ($urandom_range(0, 3) == 0);
      x.busy = 4'($urandom_range(0, 15));
      x.spec = 4'($urandom_range(0, 15));
      x.ack  = 4'($urandom_range(0, 15));
      cycle(x);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mptw_pipeline_ctrl.md
# mptw_pipeline_ctrl

Parametrised control unit for the MPT walker pipeline; generalises the flush/stall controller to `STAGES_NUM` stages. It gates the system-to-pipeline valid/ready handshake. It drives a per-stage flush command and tracks per-stage flush acknowledges. It supports selective speculative flushes, flushes while stalled, and flush upgrade (SPEC→ALL). It sits between the CPU-side request interface and the walker stages, alongside the stage control/status buses.

## Interface
- `STAGES_NUM`, 4, number of controlled stages (≥1).
- `FLUSH_TIMEOUT_CYCLES`, 64, flush watchdog limit (used only with the configuration macro).
- `clk_i` in 1: clock.
- `rst_i` in 1: reset; one clock; synchronous, active-high.
- `valid_req_i` in 1: new transaction presented.
- `flush_all_i` / `flush_spec_i` in 1: external flush requests, single-cycle pulses; ALL wins if both are high.
- `error_i` in 1: internal stage error; treated exactly as `flush_all_i`.
- `stall_i` in 1: external stall.
- `pipeline_valid_i`, `pipeline_ready_i` in 1: pipeline-side handshake.
- `system_valid_o`, `system_ready_o` out 1: gated handshake toward the system.
- `stage_busy_i` in STAGES_NUM: stage holds a transaction.
- `stage_spec_i` in STAGES_NUM: stage holds a speculative transaction.
- `flush_ack_i` in STAGES_NUM: stage reports flush completed (level, sampled each cycle).
- `flush_ctrl_o` out 2×STAGES_NUM: per-stage command; 0=NONE, 1=SPEC, 2=ALL.
- `busy_o`, `stalled_o` out 1: status.
- `flush_done_o` out 1: one-cycle pulse when a flush completes.
- `flush_timeout_o` out 1: one-cycle pulse on a watchdog-forced completion.

## Operation
- `stall_cond = stall_i | ~pipeline_ready_i`.
- `flush_req` is ALL if `flush_all_i | error_i`, else SPEC if `flush_spec_i`, else none.
- States: IDLE, RUNNING, FLUSH, STALL, STALL_FLUSH. A SPEC flush is a FLUSH with type SPEC.
- **IDLE / RUNNING**, checked in priority order:
  - flush_req → FLUSH, or STALL_FLUSH if `stall_cond`.
  - else `stall_cond` → STALL.
  - else `valid_req_i & pipeline_ready_i` or `|stage_busy_i` → RUNNING.
  - else → IDLE.
- **Flush entry**:
  - ALL: `pending = all ones`, type=ALL.
  - SPEC: `pending = stage_spec_i` sampled at the request cycle, type=SPEC.
- **Per-stage command**: `flush_ctrl_o[i] = type` while `pending[i]`, else NONE.
- **Acknowledge**: `flush_ack_i[i]` clears `pending[i]`. Acks from non-pending stages are ignored.
- **During FLUSH / STALL_FLUSH**:
  - New ALL request: upgrades type to ALL and sets `pending` to all ones.
  - New SPEC request while type=SPEC: ORs `stage_spec_i` into `pending`.
  - SPEC request while type=ALL: ignored.
- **Completion**, when `pending` becomes zero:
  - `flush_done_o` pulses and type returns to NONE.
  - Next state is STALL if `stall_cond`, else RUNNING if `valid_req_i`, else IDLE.
  - A SPEC flush with an empty captured mask completes on the first FLUSH cycle.
- **Stall transitions**:
  - STALL → IDLE/RUNNING (same rule as IDLE) when `stall_cond` drops.
  - STALL_FLUSH ↔ FLUSH follows `stall_cond`.
- **Handshake gating**:
  - `system_valid_o`/`system_ready_o` equal `pipeline_valid_i`/`pipeline_ready_i` in IDLE/RUNNING.
  - Both are forced to 0 in FLUSH, STALL and STALL_FLUSH.
  - Both are also forced to 0 in any IDLE/RUNNING cycle with a flush_req or `stall_cond`.
- **Status outputs**:
  - `busy_o`: 0 in IDLE, 1 in FLUSH/STALL_FLUSH, `|stage_busy_i` in RUNNING/STALL.
  - `stalled_o`: 1 in STALL/STALL_FLUSH.

## Timing
- Reset values: state IDLE, `pending`=0.
  - Registered outputs: `flush_ctrl_o`=0, `flush_done_o`=0, `flush_timeout_o`=0.
  - Combinational outputs (they follow inputs while in IDLE): `busy_o`=0, `stalled_o`=0, `system_*_o` = pipeline inputs.
- Reset asserted mid-flush: next cycle all state and outputs are at reset values; no `flush_done_o`.
- `flush_ctrl_o`, `flush_done_o` and `flush_timeout_o` are registered. `system_*_o`, `busy_o` and `stalled_o` are combinational from state and inputs.
- Flush requested at cycle T: state and `flush_ctrl_o` active at T+1.
- Ack sampled at cycle A: `flush_ctrl_o[i]`=NONE at A+1.
- Last ack at cycle A: `flush_done_o`=1 and the post-flush state take effect at A+1; `flush_done_o` lasts 1 cycle.
- Minimum ALL flush (all acks high at T+1): done at T+2.

## Configuration
- `MPTW_CTRL_FLUSH_TIMEOUT_EN` defined:
  - A counter clears on flush entry and on every upgrade, and increments each FLUSH/STALL_FLUSH cycle.
  - On reaching `FLUSH_TIMEOUT_CYCLES` with `pending`≠0, `pending` is cleared.
  - Completion then follows the normal rules, with `flush_timeout_o` and `flush_done_o` pulsing in the same cycle.
- Macro undefined: no counter, `flush_timeout_o` tied to 0, and a flush waits indefinitely for acks.

## Test plan
- **Single-stage acks.** Reset, then `flush_all_i` at T with STAGES_NUM=4 and acks one stage per cycle from T+1.
  - Required: `flush_ctrl_o`=2 on all four at T+1, each dropping the cycle after its ack.
  - Required: `flush_done_o` at T+5, then IDLE.
- **Selective SPEC flush.** `flush_spec_i` with `stage_spec_i`=4'b0101.
  - Required: only stages 0 and 2 see 1.
  - Required: acks on stages 1 and 3 are ignored; done after acks on 0 and 2.
- **Upgrade to ALL.** SPEC flush pending on stage 2, then `flush_all_i`.
  - Required: all stages show 2 the next cycle; done only after all four ack.
- **Stall overlap.** `stall_i` high during a flush.
  - Required: STALL_FLUSH with `stalled_o`=1 and `system_ready_o`=0.
  - Required: after the acks, `flush_done_o` pulses, state goes to STALL, and the state reaches IDLE/RUNNING one cycle after `stall_i` drops.
- **Handshake gating.** `valid_req_i` with `pipeline_ready_i`=0.
  - Required: STALL, both `system_*_o`=0.
  - Required: when ready returns, RUNNING and pass-through.
- **Watchdog (with `MPTW_CTRL_FLUSH_TIMEOUT_EN`, FLUSH_TIMEOUT_CYCLES=8).** ALL flush with stage 3 never acking.
  - Required: `flush_timeout_o` and `flush_done_o` pulse together after 8 flush cycles.
